// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quadrature decoder.
package quad_pkg;

    // Resolution select values
    localparam logic [1:0] MODE_X4 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X1 = 2'b10;

    // Gray states written as {A,B}
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } quad_state_e;

    // Next state in the forward (up) direction
    function automatic logic [1:0] gray_next_fwd(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            S00:     n = S10;
            S10:     n = S11;
            S11:     n = S01;
            S01:     n = S00;
            default: n = S00;
        endcase
        return n;
    endfunction

    // Whether a legal single-phase step counts at the given resolution
    function automatic logic step_qualifies(input logic [1:0] mode,
                                            input logic [1:0] prev,
                                            input logic [1:0] cur);
        logic q;
        case (mode)
            MODE_X4: q = 1'b1;
            MODE_X2: q = (prev[1] != cur[1]);
            MODE_X1: q = ((prev == S00) && (cur == S10)) ||
                         ((prev == S10) && (cur == S00));
            2'b11:   q = 1'b1;
            default: q = 1'b1;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/quad_phase_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample level filter.
module quad_phase_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic LOAD,
    input  logic D_IN,
    output logic Q_FILT
);

    localparam logic [3:0] FLT_LEN = 4'(FILTER_LEN);

    logic       ff1_r;
    logic       ff2_r;
    logic       filt_r;
    logic [3:0] cnt_r;

    // Synchronise the asynchronous phase input
    always_ff @(posedge CLK) begin
        if (RST) begin
            ff1_r <= 1'b0;
            ff2_r <= 1'b0;
        end else begin
            ff1_r <= D_IN;
            ff2_r <= ff1_r;
        end
    end

    // Accept a new level only after it has held for FILTER_LEN samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            filt_r <= 1'b0;
            cnt_r  <= 4'd0;
        end else if (LOAD) begin
            filt_r <= ff2_r;
            cnt_r  <= 4'd0;
        end else if (ff2_r == filt_r) begin
            cnt_r  <= 4'd0;
        end else if ((cnt_r + 4'd1) == FLT_LEN) begin
            filt_r <= ff2_r;
            cnt_r  <= 4'd0;
        end else begin
            cnt_r  <= cnt_r + 4'd1;
        end
    end

    assign Q_FILT = filt_r;

endmodule

// File: rtl/quad_decoder_169.sv
// Quadrature decoder: settle FSM, Gray transition decode, resolution
// qualification and registered counter-control outputs.
module quad_decoder_169
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PH_A,
    input  logic       PH_B,
    input  logic [1:0] MODE,
    input  logic       EN,
    input  logic       ERR_CLR,
    output logic       U_DB,
    output logic       ENPB,
    output logic       ENTB,
    output logic       ERR
);

    // Settle lasts FILTER_LEN+2 cycles; the final one lets the tracked
    // state catch up with the filters before decoding starts.
    localparam logic [4:0] SETTLE_LAST = 5'(FILTER_LEN + 1);

    quad_state_e state_r;
    logic [4:0]  settle_cnt_r;
    logic [1:0]  prev_r;
    logic        u_db_r;
    logic        enpb_r;
    logic        err_r;

    logic        qa_s;
    logic        qb_s;
    logic        load_s;
    logic [1:0]  cur_s;
    logic        step_s;
    logic        illegal_s;
    logic        up_s;
    logic        qual_s;

    quad_phase_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .CLK    (CLK),
        .RST    (RST),
        .LOAD   (load_s),
        .D_IN   (PH_A),
        .Q_FILT (qa_s)
    );

    quad_phase_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .CLK    (CLK),
        .RST    (RST),
        .LOAD   (load_s),
        .D_IN   (PH_B),
        .Q_FILT (qb_s)
    );

    // Filter bypass while settling, except on the last settle cycle
    always_comb begin
        load_s = 1'b0;
        if ((state_r == ST_SETTLE) && (settle_cnt_r != SETTLE_LAST)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Classify the change between tracked and current filtered state
    always_comb begin
        cur_s     = {qa_s, qb_s};
        step_s    = (cur_s != prev_r);
        illegal_s = ((cur_s ^ prev_r) == 2'b11);
        up_s      = (cur_s == gray_next_fwd(prev_r));
        qual_s    = step_qualifies(MODE, prev_r, cur_s);
    end

    // Settle/run FSM with registered direction, enable and error outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= 5'd0;
            prev_r       <= S00;
            u_db_r       <= 1'b1;
            enpb_r       <= 1'b1;
            err_r        <= 1'b0;
        end else begin
            enpb_r <= 1'b1;
            case (state_r)
                ST_SETTLE: begin
                    prev_r <= cur_s;
                    if (ERR_CLR) begin
                        err_r <= 1'b0;
                    end
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r      <= ST_RUN;
                        settle_cnt_r <= 5'd0;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (step_s) begin
                        prev_r <= cur_s;
                        if (!illegal_s && qual_s && EN) begin
                            enpb_r <= 1'b0;
                            u_db_r <= up_s;
                        end
                    end
                    // An illegal decode outranks a simultaneous clear
                    if (step_s && illegal_s) begin
                        err_r <= 1'b1;
                    end else if (ERR_CLR) begin
                        err_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_SETTLE;
                    settle_cnt_r <= 5'd0;
                end
            endcase
        end
    end

    assign U_DB = u_db_r;
    assign ENPB = enpb_r;
    assign ENTB = enpb_r;
    assign ERR  = err_r;

endmodule

// File: tb/tb_quad_decoder_169.sv
// Randomised self-checking bench for quad_decoder_169 against a
// position-based quadrature model.
module tb_quad_decoder_169;

    localparam int FL  = 3;
    localparam int LAT = FL + 3;   // sample index of the pulse after a level change

    logic       CLK = 1'b0;
    logic       RST;
    logic       PH_A;
    logic       PH_B;
    logic [1:0] MODE;
    logic       EN;
    logic       ERR_CLR;
    logic       U_DB;
    logic       ENPB;
    logic       ENTB;
    logic       ERR;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [1:0] m_state;
    logic       m_err;
    logic       m_udb;
    logic [3:0] m_q;
    logic [3:0] d_q;       // downstream counter driven by DUT outputs
    int         win_pulses;

    quad_decoder_169 #(.FILTER_LEN(FL)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PH_A    (PH_A),
        .PH_B    (PH_B),
        .MODE    (MODE),
        .EN      (EN),
        .ERR_CLR (ERR_CLR),
        .U_DB    (U_DB),
        .ENPB    (ENPB),
        .ENTB    (ENTB),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Position of a state along the forward cycle 00,10,11,01
    function automatic int pos_of(input logic [1:0] s);
        int p;
        case (s)
            2'b00:   p = 0;
            2'b10:   p = 1;
            2'b11:   p = 2;
            default: p = 3;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] st_of(input int p);
        logic [1:0] s;
        case (p % 4)
            0:       s = 2'b00;
            1:       s = 2'b10;
            2:       s = 2'b11;
            default: s = 2'b01;
        endcase
        return s;
    endfunction

    // Expected outcome of moving from prev to cur at the current MODE/EN
    task automatic predict(input logic [1:0] prev, input logic [1:0] cur,
                           output logic pulse, output logic up, output logic illegal);
        int pp, pc, d;
        logic qual;
        pp = pos_of(prev);
        pc = pos_of(cur);
        d  = (pc - pp + 4) % 4;
        pulse = 1'b0; up = 1'b0; illegal = 1'b0;
        if (d == 2) begin
            illegal = 1'b1;
        end else if (d != 0) begin
            up = (d == 1);
            if (MODE == 2'b01)      qual = ((pp / 2) == (pc / 2));
            else if (MODE == 2'b10) qual = ((pp + pc) == 1);
            else                    qual = 1'b1;
            pulse = qual && EN;
        end
    endtask

    // Watch n cycles, counting pulses and feeding the downstream counter
    task automatic watch(input int n, input int clr_at, output int pulses,
                         output int at_idx, output int entb_bad);
        pulses = 0; at_idx = 0; entb_bad = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (ENTB !== ENPB) entb_bad++;
            if (ENPB === 1'b0) begin
                pulses++;
                at_idx = i;
                d_q = U_DB ? d_q + 4'd1 : d_q - 4'd1;
            end
            ERR_CLR = ((i + 1) == clr_at);
        end
        ERR_CLR = 1'b0;
    endtask

    // Move the phases to cur, hold, and compare against the model
    task automatic do_step(input logic [1:0] cur, input int hold, input int clr_at);
        logic pulse, up, illegal;
        int pulses, at_idx, entb_bad;
        predict(m_state, cur, pulse, up, illegal);
        {PH_A, PH_B} = cur;
        watch(hold, clr_at, pulses, at_idx, entb_bad);
        if (illegal) m_err = 1'b1;
        if (pulse) begin
            m_udb = up;
            m_q   = up ? m_q + 4'd1 : m_q - 4'd1;
        end
        m_state = cur;
        win_pulses += pulses;
        check_eq("pulse_count", pulses, {31'd0, pulse});
        if (pulse) check_eq("pulse_latency", at_idx, LAT);
        check_eq("u_db", {31'd0, U_DB}, {31'd0, m_udb});
        check_eq("err", {31'd0, ERR}, {31'd0, m_err});
        check_eq("counter_q", {28'd0, d_q}, {28'd0, m_q});
        check_eq("entb_eq_enpb", entb_bad, 0);
    endtask

    task automatic walk(input int dir, input int n);
        for (int i = 0; i < n; i++)
            do_step(st_of(pos_of(m_state) + (dir > 0 ? 1 : 3)), $urandom_range(FL + 6, FL + 11), 0);
    endtask

    task automatic clear_err();
        ERR_CLR = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        ERR_CLR = 1'b0;
        m_err = 1'b0;
        check_eq("err_clear", {31'd0, ERR}, 32'd0);
    endtask

    task automatic glitch_a(input int width);
        int pulses, at_idx, entb_bad;
        PH_A = ~m_state[1];
        repeat (width) @(negedge CLK);
        PH_A = m_state[1];
        watch(FL + 6, 0, pulses, at_idx, entb_bad);
        check_eq("glitch_reject", pulses, 0);
        check_eq("glitch_err", {31'd0, ERR}, {31'd0, m_err});
    endtask

    initial begin
        int pulses, at_idx, entb_bad;
        logic [1:0] nxt;
        int r;
        RST = 1'b1; PH_A = 1'b0; PH_B = 1'b0; MODE = 2'b00; EN = 1'b1; ERR_CLR = 1'b0;
        m_state = 2'b00; m_err = 1'b0; m_udb = 1'b1; m_q = 4'd0; d_q = 4'd0; win_pulses = 0;
        repeat (4) @(negedge CLK);
        check_eq("rst_u_db", {31'd0, U_DB}, 32'd1);
        check_eq("rst_enpb", {31'd0, ENPB}, 32'd1);
        check_eq("rst_entb", {31'd0, ENTB}, 32'd1);
        check_eq("rst_err",  {31'd0, ERR},  32'd0);
        RST = 1'b0;
        watch(FL + 6, 0, pulses, at_idx, entb_bad);
        check_eq("settle_quiet", pulses, 0);

        // x4 up then down through one full cycle each
        walk(1, 4);
        check_eq("x4_up_q", {28'd0, d_q}, 32'd4);
        walk(-1, 4);
        check_eq("x4_down_q", {28'd0, d_q}, 32'd0);

        // Short pulses rejected, a FILTER_LEN-wide level accepted
        glitch_a(1);
        glitch_a(FL - 1);
        do_step(2'b10, FL + 6, 0);
        do_step(2'b00, FL + 6, 0);

        // Illegal transition, clear, then clear coinciding with an illegal decode
        do_step(2'b11, FL + 6, 0);
        clear_err();
        do_step(2'b00, FL + 6, LAT);
        check_eq("err_set_wins", {31'd0, ERR}, 32'd1);
        clear_err();

        // Resolution and enable over full forward cycles
        MODE = 2'b10; win_pulses = 0; walk(1, 4);
        check_eq("x1_cycle_pulses", win_pulses, 1);
        MODE = 2'b01; win_pulses = 0; walk(1, 4);
        check_eq("x2_cycle_pulses", win_pulses, 2);
        MODE = 2'b00; EN = 1'b0; win_pulses = 0; walk(1, 4);
        check_eq("en0_cycle_pulses", win_pulses, 0);
        EN = 1'b1;
        do_step(2'b10, FL + 6, 0);
        do_step(2'b11, FL + 6, 0);

        // Reset mid-operation while parked at 11
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("midrst_enpb", {31'd0, ENPB}, 32'd1);
        RST = 1'b0;
        m_err = 1'b0; m_udb = 1'b1;
        watch(FL + 8, 0, pulses, at_idx, entb_bad);
        check_eq("midrst_pulses", pulses, 0);
        check_eq("midrst_err", {31'd0, ERR}, 32'd0);
        check_eq("midrst_u_db", {31'd0, U_DB}, 32'd1);
        do_step(2'b01, FL + 6, 0);

        // Randomised steps with random mode and enable
        for (int k = 0; k < 60; k++) begin
            MODE = 2'($urandom_range(0, 3));
            EN   = ($urandom_range(0, 3) != 0);
            r    = $urandom_range(0, 9);
            if (r == 0)     nxt = m_state ^ 2'b11;
            else if (r < 5) nxt = st_of(pos_of(m_state) + 1);
            else            nxt = st_of(pos_of(m_state) + 3);
            do_step(nxt, $urandom_range(FL + 6, FL + 11), 0);
            if (m_err && ($urandom_range(0, 2) == 0)) clear_err();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder_169.md
Name: quad_decoder_169

Overview:
Quadrature front end that drives the team's 4-bit up/down counter. Each phase input is synchronised and glitch-filtered, then Gray-code transitions are decoded. The block produces the counter's direction (U_DB) and active-low count enables (ENPB/ENTB), one pulse per qualified step. It also detects illegal double-phase transitions.

Parameters:
FILTER_LEN, 3, consecutive synchronised samples a new phase level must hold before it is accepted (1..15).
MODE_RESET, 2'b00, MODE value applied by the bench or top level when unconfigured (x4). Informational only; MODE is a live input.

Ports:
CLK  input  1  system clock, all logic on posedge.
RST  input  1  synchronous, active-high reset.
PH_A  input  1  quadrature phase A, asynchronous.
PH_B  input  1  quadrature phase B, asynchronous.
MODE  input  2  resolution: 00=x4, 01=x2, 10=x1, 11=x4.
EN  input  1  1=emit count pulses; 0=track state but suppress pulses.
ERR_CLR  input  1  clears ERR.
U_DB  output  1  direction to counter: 1=up, 0=down; registered.
ENPB  output  1  active-low count enable, pulsed.
ENTB  output  1  active-low count enable; always equal to ENPB.
ERR  output  1  sticky illegal-transition flag.

Behaviour:
- Interface decision: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: U_DB=1, ENPB=ENTB=1, ERR=0. Sync FFs=0, filter counters=0, filtered state=00, FSM=SETTLE, settle counter=0.
- Synchroniser: 2 FFs per phase (ff1, ff2). The filter sees only ff2.
- Filter, per phase:
  - If ff2 equals the filtered value, the mismatch counter is cleared.
  - Otherwise the counter increments. On the edge it reaches FILTER_LEN, the filtered value takes ff2 and the counter clears.
  - Pulses shorter than FILTER_LEN cycles at ff2 are rejected.
- FSM SETTLE:
  - Lasts FILTER_LEN+2 cycles after RST deasserts.
  - Each cycle the filtered state loads ff2 directly, with no decode, no pulses and no ERR.
  - Then the FSM goes to RUN.
- FSM RUN: on any edge where the filtered state {A,B} changes from prev to cur, the transition is decoded and registered on the next edge.
- Forward (up) sequence: 00->10->11->01->00. Reverse (down) sequence is the opposite order.
- Qualified steps by mode:
  - x4: every legal transition.
  - x2: only transitions where A changes (00<->10, 11<->01).
  - x1: only 00->10 (up) and 10->00 (down).
- Pulse output:
  - A qualified step with EN=1 drives ENPB=ENTB=0 for exactly one cycle.
  - U_DB is updated on the same edge; U_DB holds its last value otherwise.
  - A non-qualified or EN=0 step updates the tracked state only.
- Latency: with edge k the first to sample a new level into ff1, the pulse is visible after edge k+FILTER_LEN+2 (k+5 at default).
- Illegal transition (both phases change on the same filtered edge, e.g. 00->11):
  - ERR<=1, no pulse, U_DB unchanged.
  - The tracked state adopts cur.
- ERR_CLR=1 clears ERR next edge. If an illegal transition occurs on the same edge, set wins and ERR stays 1.
- Maximum step rate: one qualified step per FILTER_LEN+1 cycles. Faster inputs are outside spec; expect filtering loss or ERR.
- MODE change takes effect on the next decoded transition; no pulse is generated by the change itself.
- RST mid-operation: outputs return to reset values on that edge and SETTLE restarts. Current input levels are adopted silently, with no pulse or ERR after release.

Decomposition:
- Shared package quad_pkg holds:
  - MODE constants MODE_X4=2'b00, MODE_X2=2'b01, MODE_X1=2'b10.
  - FSM encoding ST_SETTLE, ST_RUN.
  - Gray state constants S00, S10, S11, S01.
- Sub-module quad_phase_filter: one instance per phase, containing the 2-FF synchroniser plus the FILTER_LEN filter. Ports CLK, RST, LOAD (SETTLE bypass), D_IN, Q_FILT.
- Top level holds the FSM, transition decode, MODE qualification and output registers.

Test Plan:
- x4 up count: RST 4 cycles, PH=00, FILTER_LEN=3, MODE=00, EN=1. Step 00->10->11->01->00, holding each level 8 cycles, with the downstream counter starting at Q=0. Expect 4 single-cycle ENPB/ENTB low pulses, U_DB=1 on each, first pulse 5 edges after the first sampling edge, counter Q=4, ERR=0.
- x4 down count: from 00, step 00->01->11->10->00. Expect 4 pulses with U_DB=0; counter wraps from 4 back to 0.
- Glitch filter: PH_A high for 2 cycles then low -> no pulse. PH_A high for 3 cycles and held -> exactly 1 pulse, U_DB=1.
- Illegal transition: from 00, drive PH_A and PH_B high on the same cycle. Expect ERR=1, no pulse. Pulse ERR_CLR -> ERR=0 next edge. Repeat with ERR_CLR asserted on the edge of an illegal decode -> ERR stays 1.
- Resolution and enable:
  - One full forward cycle at MODE=10 -> 1 pulse; at MODE=01 -> 2 pulses.
  - EN=0 for the full cycle -> 0 pulses; a subsequent step with EN=1 decodes correctly from the tracked state.
- Reset mid-operation: hold PH=11, assert RST mid-sequence, release. Expect no pulse and ERR=0 through SETTLE. A step 11->01 afterwards gives 1 pulse with U_DB=1.
